// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : MEM stage of the pipelined ARMv8 core. Issues 64-bit data
//             memory accesses over a req/ack handshake, stalls upstream while
//             an access is outstanding, aborts on timeout or misalignment and
//             registers the MEM/WB outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [4:0]            rd,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemToReg,
    input  logic                  RegWrite,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_RegWrite,
    output logic                  fault
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [4:0]        XZR      = 5'd31;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [4:0]            rd_q, rd_d;
    logic                  regwr_q, regwr_d;
    logic                  m2r_q, m2r_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic                  wb_regwr_q, wb_regwr_d;
    logic                  fault_q, fault_d;

    logic                  mem_op;
    logic                  misaligned;

    assign mem_op     = in_valid & (MemRead | MemWrite);
    assign misaligned = (alu_result[2:0] != 3'b000);

    // Next-state, request and write-back selection; stall is combinational.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_d        = rd_q;
        regwr_d     = regwr_q;
        m2r_d       = m2r_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        // Pulsed outputs clear unless a completion happens this cycle.
        wb_valid_d  = 1'b0;
        wb_regwr_d  = 1'b0;
        fault_d     = 1'b0;
        stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!mem_op) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_result;
                        wb_rd_d    = rd;
                        wb_regwr_d = RegWrite && (rd != XZR);
                    end else if (misaligned) begin
                        // Rejected without touching memory.
                        wb_valid_d = 1'b1;
                        fault_d    = 1'b1;
                        wb_data_d  = alu_result;
                        wb_rd_d    = rd;
                    end else begin
                        stall       = 1'b1;
                        state_d     = ST_WAIT;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        // A store wins when both MemRead and MemWrite are set.
                        mem_we_d    = MemWrite;
                        mem_addr_d  = alu_result;
                        mem_wdata_d = write_data;
                        rd_d        = rd;
                        regwr_d     = RegWrite;
                        m2r_d       = MemToReg;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    // Ack takes priority over a timeout in the same cycle.
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_regwr_d = regwr_q && (rd_q != XZR);
                    wb_data_d  = m2r_q ? mem_rdata : mem_addr_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    fault_d    = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = mem_addr_q;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Upstream must not see a stall while the core is held in reset.
        if (!reset) begin
            stall = 1'b0;
        end
    end

    // Pipeline and handshake registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_q        <= '0;
            regwr_q     <= 1'b0;
            m2r_q       <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_regwr_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_q        <= rd_d;
            regwr_q     <= regwr_d;
            m2r_q       <= m2r_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_regwr_q  <= wb_regwr_d;
            fault_q     <= fault_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_RegWrite = wb_regwr_q;
    assign fault       = fault_q;

endmodule
`default_nettype wire
